// File: rtl/dmem_arbiter_if.sv
// Request/response port between one DMEM master and the arbiter.
// The master drives the request fields; the arbiter returns grant and response.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port DMEM: grant, one-entry access slot, registered response.
// P0 wins by default; P1 is forced through after STARVE_MAX consecutive lost cycles.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     p0,
    dmem_arbiter_if.slave     p1,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    output logic              dmem_we_o,
    output logic              dmem_re_o,
    input  logic [DATA_W-1:0] dmem_rdata_i
);

    localparam int                  STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    localparam logic [ADDR_W:0]     ADDR_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

    logic [STARVE_W-1:0] starve_q, starve_d;

    logic              s_valid_q;
    logic              s_owner_q;
    logic              s_we_q;
    logic              s_err_q;
    logic [ADDR_W-1:0] s_addr_q;
    logic [DATA_W-1:0] s_wdata_q;

    logic              p0_rvalid_q, p1_rvalid_q;
    logic              p0_err_q, p1_err_q;
    logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;

    logic              p1_wins;
    logic              p0_gnt, p1_gnt, gnt_any;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;
    logic              access;
    logic [DATA_W-1:0] resp_rdata;

    always_comb begin
        p1_wins = p1.req & (~p0.req | (starve_q == STARVE_LIM));
        p1_gnt  = p1_wins & ~reset;
        p0_gnt  = p0.req & ~p1_wins & ~reset;
        gnt_any = p0_gnt | p1_gnt;

        sel_we    = p1_gnt ? p1.we    : p0.we;
        sel_addr  = p1_gnt ? p1.addr  : p0.addr;
        sel_wdata = p1_gnt ? p1.wdata : p0.wdata;
        sel_err   = ({1'b0, sel_addr} >= ADDR_LIMIT);
    end

    // P1 losing while requesting bumps the counter; any P1 win or idle P1 clears it.
    always_comb begin
        starve_d = starve_q;
        if (!p1.req || p1_gnt) begin
            starve_d = '0;
        end else if (p0_gnt && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q  <= '0;
            s_valid_q <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            s_valid_q <= gnt_any;
            if (gnt_any) begin
                s_owner_q <= p1_gnt;
                s_we_q    <= sel_we;
                s_err_q   <= sel_err;
                s_addr_q  <= sel_addr;
                s_wdata_q <= sel_wdata;
            end
        end
    end

    // Reset during the access cycle must suppress the DMEM write at that edge.
    always_comb begin
        access       = s_valid_q & ~reset;
        dmem_addr_o  = access ? s_addr_q  : '0;
        dmem_wdata_o = access ? s_wdata_q : '0;
        dmem_we_o    = access & s_we_q & ~s_err_q;
        dmem_re_o    = access & ~s_we_q & ~s_err_q;
        resp_rdata   = (~s_we_q & ~s_err_q) ? dmem_rdata_i : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            p0_rvalid_q <= s_valid_q & ~s_owner_q;
            p1_rvalid_q <= s_valid_q & s_owner_q;
            if (s_valid_q && !s_owner_q) begin
                p0_err_q   <= s_err_q;
                p0_rdata_q <= resp_rdata;
            end
            if (s_valid_q && s_owner_q) begin
                p1_err_q   <= s_err_q;
                p1_rdata_q <= resp_rdata;
            end
        end
    end

    assign p0.gnt    = p0_gnt;
    assign p1.gnt    = p1_gnt;
    assign p0.rvalid = p0_rvalid_q;
    assign p1.rvalid = p1_rvalid_q;
    assign p0.err    = p0_err_q;
    assign p1.err    = p1_err_q;
    assign p0.rdata  = p0_rdata_q;
    assign p1.rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port DMEM (comb read, posedge write).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic        dmem_re;
    logic [31:0] dmem_rdata;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int acc_snap;

    logic [31:0] mem [0:1023];

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p0_bus ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p1_bus ();

    dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_WORDS(1024), .STARVE_MAX(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .p0           (p0_bus),
        .p1           (p1_bus),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata),
        .dmem_we_o    (dmem_we),
        .dmem_re_o    (dmem_re),
        .dmem_rdata_i (dmem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dmem_we) mem[dmem_addr[9:0]] <= dmem_wdata;
    assign dmem_rdata = (dmem_addr < 32'd1024) ? mem[dmem_addr[9:0]] : 32'h0;

    always @(negedge clk) if (dmem_we || dmem_re) acc_cnt <= acc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        p0_bus.req = req; p0_bus.we = we; p0_bus.addr = addr; p0_bus.wdata = wdata;
    endtask

    task automatic drv1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        p1_bus.req = req; p1_bus.we = we; p1_bus.addr = addr; p1_bus.wdata = wdata;
    endtask

    initial begin
        reset = 1'b1;
        drv0(1'b1, 1'b0, 32'd0, 32'd0);
        drv1(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        chk("gnt_in_reset", {31'd0, p0_bus.gnt}, 32'd0);
        drv0(1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_p0_rvalid", {31'd0, p0_bus.rvalid}, 32'd0);
        chk("rst_p1_rvalid", {31'd0, p1_bus.rvalid}, 32'd0);
        chk("rst_p0_rdata", p0_bus.rdata, 32'd0);
        chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_dmem_re", {31'd0, dmem_re}, 32'd0);
        tick();

        // 1: write then read of addr 5
        drv0(1'b1, 1'b1, 32'd5, 32'hDEADBEEF);
        #1 chk("t1_wr_gnt", {31'd0, p0_bus.gnt}, 32'd1);
        tick();
        chk("t1_dmem_we", {31'd0, dmem_we}, 32'd1);
        chk("t1_dmem_addr", dmem_addr, 32'd5);
        chk("t1_dmem_wdata", dmem_wdata, 32'hDEADBEEF);
        chk("t1_no_rvalid_yet", {31'd0, p0_bus.rvalid}, 32'd0);
        drv0(1'b1, 1'b0, 32'd5, 32'd0);
        #1 chk("t1_rd_gnt", {31'd0, p0_bus.gnt}, 32'd1);
        tick();
        chk("t1_wr_rvalid", {31'd0, p0_bus.rvalid}, 32'd1);
        chk("t1_wr_rdata", p0_bus.rdata, 32'd0);
        chk("t1_dmem_re", {31'd0, dmem_re}, 32'd1);
        drv0(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk("t1_rd_rvalid", {31'd0, p0_bus.rvalid}, 32'd1);
        chk("t1_rd_rdata", p0_bus.rdata, 32'hDEADBEEF);
        chk("t1_rd_err", {31'd0, p0_bus.err}, 32'd0);
        tick();
        chk("t1_rvalid_pulse", {31'd0, p0_bus.rvalid}, 32'd0);

        // 6: P1 alone gets an immediate grant
        drv1(1'b1, 1'b0, 32'd5, 32'd0);
        #1 chk("t6_p1_gnt", {31'd0, p1_bus.gnt}, 32'd1);
        chk("t6_p0_gnt", {31'd0, p0_bus.gnt}, 32'd0);
        tick();
        drv1(1'b0, 1'b0, 32'd0, 32'd0);
        chk("t6_starve", {28'd0, dut.starve_q}, 32'd0);
        chk("t6_dmem_re", {31'd0, dmem_re}, 32'd1);
        tick();
        chk("t6_p1_rvalid", {31'd0, p1_bus.rvalid}, 32'd1);
        chk("t6_p1_rdata", p1_bus.rdata, 32'hDEADBEEF);
        chk("t6_p0_rvalid", {31'd0, p0_bus.rvalid}, 32'd0);
        tick();

        // 4: preload 0..2 then back-to-back reads
        drv0(1'b1, 1'b1, 32'd0, 32'h10);
        #1 chk("t4_w0_gnt", {31'd0, p0_bus.gnt}, 32'd1);
        tick();
        drv0(1'b1, 1'b1, 32'd1, 32'h11);
        tick();
        drv0(1'b1, 1'b1, 32'd2, 32'h12);
        tick();
        drv0(1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        drv0(1'b1, 1'b0, 32'd1, 32'd0);
        tick();
        chk("t4_r0_rvalid", {31'd0, p0_bus.rvalid}, 32'd1);
        chk("t4_r0_rdata", p0_bus.rdata, 32'h10);
        drv0(1'b1, 1'b0, 32'd2, 32'd0);
        tick();
        chk("t4_r1_rvalid", {31'd0, p0_bus.rvalid}, 32'd1);
        chk("t4_r1_rdata", p0_bus.rdata, 32'h11);
        drv0(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk("t4_r2_rvalid", {31'd0, p0_bus.rvalid}, 32'd1);
        chk("t4_r2_rdata", p0_bus.rdata, 32'h12);
        tick();

        // 2: both masters requesting every cycle
        drv0(1'b1, 1'b0, 32'd0, 32'd0);
        drv1(1'b1, 1'b0, 32'd1, 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (i >= 2) begin
                chk("t2_p1_rvalid", {31'd0, p1_bus.rvalid}, ((i - 2) % 5 == 4) ? 32'd1 : 32'd0);
                chk("t2_p0_rvalid", {31'd0, p0_bus.rvalid}, ((i - 2) % 5 == 4) ? 32'd0 : 32'd1);
            end
            #1;
            chk("t2_p0_gnt", {31'd0, p0_bus.gnt}, (i % 5 == 4) ? 32'd0 : 32'd1);
            chk("t2_p1_gnt", {31'd0, p1_bus.gnt}, (i % 5 == 4) ? 32'd1 : 32'd0);
            tick();
        end
        drv0(1'b0, 1'b0, 32'd0, 32'd0);
        drv1(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        tick();

        // 3: out-of-range read (P1) and write (P0)
        acc_snap = acc_cnt;
        drv1(1'b1, 1'b0, 32'd1024, 32'd0);
        #1 chk("t3_p1_gnt", {31'd0, p1_bus.gnt}, 32'd1);
        tick();
        drv1(1'b0, 1'b0, 32'd0, 32'd0);
        drv0(1'b1, 1'b1, 32'd2000, 32'h77);
        #1 chk("t3_dmem_re", {31'd0, dmem_re}, 32'd0);
        tick();
        drv0(1'b0, 1'b0, 32'd0, 32'd0);
        chk("t3_p1_rvalid", {31'd0, p1_bus.rvalid}, 32'd1);
        chk("t3_p1_err", {31'd0, p1_bus.err}, 32'd1);
        chk("t3_p1_rdata", p1_bus.rdata, 32'd0);
        chk("t3_dmem_we", {31'd0, dmem_we}, 32'd0);
        tick();
        chk("t3_p0_rvalid", {31'd0, p0_bus.rvalid}, 32'd1);
        chk("t3_p0_err", {31'd0, p0_bus.err}, 32'd1);
        tick();
        chk("t3_no_access", acc_cnt - acc_snap, 32'd0);

        // 5: reset during P1 write access to addr 7
        drv0(1'b1, 1'b1, 32'd7, 32'hAAAA5555);
        tick();
        drv0(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        drv1(1'b1, 1'b1, 32'd7, 32'h55);
        #1 chk("t5_p1_gnt", {31'd0, p1_bus.gnt}, 32'd1);
        tick();
        chk("t5_access_we", {31'd0, dmem_we}, 32'd1);
        drv1(1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        #1 chk("t5_we_gated", {31'd0, dmem_we}, 32'd0);
        tick();
        drv0(1'b1, 1'b0, 32'd7, 32'd0);
        #1;
        chk("t5_p0_gnt", {31'd0, p0_bus.gnt}, 32'd0);
        chk("t5_p1_rvalid", {31'd0, p1_bus.rvalid}, 32'd0);
        chk("t5_p0_rvalid", {31'd0, p0_bus.rvalid}, 32'd0);
        chk("t5_p0_rdata", p0_bus.rdata, 32'd0);
        chk("t5_p0_err", {31'd0, p0_bus.err}, 32'd0);
        chk("t5_p1_err", {31'd0, p1_bus.err}, 32'd0);
        chk("t5_dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("t5_dmem_re", {31'd0, dmem_re}, 32'd0);
        reset = 1'b0;
        tick();
        chk("t5_p1_no_resp", {31'd0, p1_bus.rvalid}, 32'd0);
        tick();
        drv0(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk("t5_rd7_rvalid", {31'd0, p0_bus.rvalid}, 32'd1);
        chk("t5_rd7_rdata", p0_bus.rdata, 32'hAAAA5555);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
